// File: rtl/serial_pattern_gen_if.sv
// serial_pattern_gen_if: command handshake and serial output bundle of the pattern generator
interface serial_pattern_gen_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = $clog2(WIDTH),
  parameter int REP_W = 4,
  parameter int CNT_W = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [LEN_W-1:0] load_len;
  logic [REP_W-1:0] load_rep;
  logic             data_out;
  logic             data_out_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] match_count;
  modport master (
    output load_valid, load_data, load_len, load_rep,
    input  load_ready, data_out, data_out_valid, busy, done, match_count
  );
  modport slave (
    input  load_valid, load_data, load_len, load_rep,
    output load_ready, data_out, data_out_valid, busy, done, match_count
  );
endinterface

// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: shifts a captured word out MSB-first with repeats and counts overlapping "101"
module serial_pattern_gen #(
  parameter int WIDTH = 16,
  parameter int LEN_W = $clog2(WIDTH),
  parameter int REP_W = 4,
  parameter int CNT_W = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_pattern_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [LEN_W-1:0] r_top;
  logic [LEN_W-1:0] r_idx;
  logic [REP_W-1:0] r_rep;
  logic [1:0]       r_hist;
  logic [CNT_W-1:0] r_count;
  logic             r_out;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic [LEN_W-1:0] w_top;
  logic             w_hit;
  // index of the first bit; len 0 wraps to WIDTH-1 because WIDTH is a power of two
  assign w_top = bus.load_len - LEN_W'(1);
  assign w_hit = r_hist == 2'b10 && r_out && !(&r_count);
  assign bus.load_ready     = r_state == IDLE && rst_n;
  assign bus.data_out       = r_out;
  assign bus.data_out_valid = r_valid;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.match_count    = r_count;
  // command FSM: capture, shift out with back-to-back repeats, single-cycle done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_top   <= '0;
      r_idx   <= '0;
      r_rep   <= '0;
      r_hist  <= '0;
      r_count <= '0;
      r_out   <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.load_valid) begin
          r_data  <= bus.load_data;
          r_top   <= w_top;
          r_idx   <= w_top;
          r_rep   <= bus.load_rep;
          r_hist  <= '0;
          r_count <= '0;
          r_out   <= bus.load_data[w_top];
          r_valid <= 1'b1;
          r_busy  <= 1'b1;
          r_state <= SEND;
        end
        SEND: begin
          r_hist <= {r_hist[0], r_out};
          if (w_hit) r_count <= r_count + CNT_W'(1);
          if (r_idx != '0) begin
            r_idx <= r_idx - LEN_W'(1);
            r_out <= r_data[r_idx - LEN_W'(1)];
          end else if (r_rep != '0) begin
            r_rep <= r_rep - REP_W'(1);
            r_idx <= r_top;
            r_out <= r_data[r_top];
          end else begin
            r_out   <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/serial_pattern_gen.md
# serial_pattern_gen

Serial pattern generator: accepts a parallel word over a valid/ready handshake and shifts it out one bit per clock, MSB-first, optionally repeated back-to-back. It is the stimulus-side partner of the serial sequence detector and drives that detector's `data_in`. It also keeps a running count of overlapping "101" occurrences in the stream it has sent, so a bench or self-test can compare that count against the detector's `sequence_detected` pulses.

## Interface
- `WIDTH`, 16: maximum frame length in bits; must be a power of two, ≥ 4.
- `LEN_W`, $clog2(WIDTH): width of `load_len`.
- `REP_W`, 4: width of `load_rep`.
- `CNT_W`, 8: width of `match_count`.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load_valid` in 1: command present.
- `load_ready` out 1: block can accept a command.
- `load_data` in WIDTH: frame bits; the frame is `load_data[len-1:0]`.
- `load_len` in LEN_W: frame length; 0 encodes WIDTH.
- `load_rep` in REP_W: extra repetitions; the frame is sent `load_rep+1` times.
- `data_out` out 1: serial bit; connects to the detector's `data_in`.
- `data_out_valid` out 1: `data_out` carries a frame bit this cycle.
- `busy` out 1: command in progress (SEND or DONE).
- `done` out 1: one-cycle pulse after the last bit.
- `match_count` out CNT_W: overlapping "101" count for the current or last command; saturating.

## Operation
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - `load_ready` = 1.
  - Accept on a rising edge with `load_valid && load_ready`.
  - At acceptance, capture data, effective length L (`load_len`, with 0 mapped to WIDTH) and `load_rep`.
  - At acceptance, clear `match_count` and the two-bit history. Go to SEND.
  - `load_valid` while not ready is ignored. No queuing.
- SEND:
  - Each cycle drives the next bit: bit L-1 first, then down to bit 0.
  - At the end of a frame, if the repeat counter is non-zero: decrement it, reload from the captured copy, and continue with no gap cycle.
  - After the final bit of the final repeat, go to DONE.
- DONE: one cycle, `done` = 1, then return to IDLE.
- Outputs outside SEND: `data_out` = 0 and `data_out_valid` = 0.
- `busy` = 1 in SEND and DONE.
- Total bits per command: N = L·(load_rep+1).
- match_count:
  - The history register holds the last two bits transmitted under the current command.
  - At the edge that ends a valid cycle, if history = "10" and the current bit = 1, increment the count.
  - The count saturates at 2^CNT_W−1.
  - Detection spans frame and repeat boundaries.
  - The count is held through DONE and IDLE until the next acceptance.
- Reset:
  - Asserting `rst_n` at any time, including mid-frame, immediately forces IDLE.
  - All outputs go to 0, including `load_ready`, which stays 0 while `rst_n` is low.
  - The bit in flight is dropped. No `done` pulse is generated.
- Reset values: `load_ready` 0 (1 from rst_n release while in IDLE), `data_out` 0, `data_out_valid` 0, `busy` 0, `done` 0, `match_count` 0.

## Timing
- All outputs are registered except `load_ready`, which is decoded from the state register (`state==IDLE && rst_n`).
- Acceptance occurs at edge E0.
- Bit k (k = 0..N−1) is valid in the cycle following edge E0+k, so the first bit appears one cycle after acceptance.
- `done` is high in the cycle following edge E0+N.
- `load_ready` returns high after edge E0+N+1.
- Command-to-command minimum spacing is N+2 cycles.
- `match_count` reflects bit k from the cycle following edge E0+k+1. Its final value is stable while `done` is high.
- The detector samples `data_out` on the edge ending each valid cycle.

## Test plan
- Load data=3'b101, len=3, rep=0:
  - `data_out` is 1,0,1 with `data_out_valid` high for 3 cycles.
  - `done` pulses at cycle 4 after acceptance.
  - `match_count` = 1.
- Load data=5'b10101, len=5, rep=0: stream 10101, `match_count` = 2 (overlap).
- Load data=2'b10, len=2, rep=2:
  - Stream 101010 with no gap cycles; `match_count` = 2 (crosses repeat boundaries).
  - `load_valid` held high during SEND is not accepted.
- Load data=16'hAAAA, len=0 (→16), rep=0: 16 bits 1010…10, `match_count` = 7. With CNT_W=3 and rep=1 (32 bits, 15 matches), `match_count` saturates at 7.
- Reset mid-operation: assert `rst_n` low at bit 5 of a 16-bit frame.
  - Outputs go to 0 immediately; no `done` pulse.
  - After release, `load_ready` = 1 and a new data=3'b101 command transmits normally with `match_count` = 1.
- Back-to-back commands: `load_valid` held high with two commands queued by the bench. The second is accepted exactly N+2 cycles after the first, and its `match_count` restarts from 0.
